// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// branch_predictor_if : fetch-lookup and execute-resolve bundle of the predictor
// Revision: 1.0
// ============================================================================
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic            ex_is_branch;
    logic [XLEN-1:0] ex_pc;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            BrEq;
    logic            BrLT;
    logic            BrUn;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     br_cnt;
    logic [31:0]     mp_cnt;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_funct3, ex_target,
               ex_pred_taken, ex_pred_target, BrEq, BrLT,
        input  pred_taken, pred_target, BrUn, mispredict, redirect_pc, br_cnt, mp_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_funct3, ex_target,
               ex_pred_taken, ex_pred_target, BrEq, BrLT,
        output pred_taken, pred_target, BrUn, mispredict, redirect_pc, br_cnt, mp_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// branch_predictor : 2-bit BHT + direct-mapped BTB, trained from BrEq/BrLT
// Revision: 1.0
// ============================================================================
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [XLEN-1:0]   r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [31:0]       r_brCnt;
    logic [31:0]       r_mpCnt;

    logic [IDX_W-1:0]  w_ifIdx;
    logic [IDX_W-1:0]  w_exIdx;
    logic              w_ifHit;
    logic              w_exHit;
    logic              w_legal;
    logic              w_taken;
    logic              w_res;
    logic              w_alias;
    logic              w_mispredict;
    logic [XLEN-1:0]   w_exPcPlus4;
    logic              w_unused;

    assign w_unused = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    // Fetch-side lookup reads only registered state: updates show up next cycle.
    assign w_ifIdx         = bp.if_pc[IDX_W+1:2];
    assign w_ifHit         = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == bp.if_pc[XLEN-1:IDX_W+2]);
    assign bp.pred_taken   = w_ifHit && r_ctr[w_ifIdx][1];
    assign bp.pred_target  = bp.pred_taken ? r_target[w_ifIdx] : '0;

    assign w_exIdx = bp.ex_pc[IDX_W+1:2];
    assign w_exHit = r_valid[w_exIdx] && (r_tag[w_exIdx] == bp.ex_pc[XLEN-1:IDX_W+2]);

    assign bp.BrUn = bp.ex_funct3[1];

    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        case (bp.ex_funct3)
            3'b000:         w_taken = bp.BrEq;
            3'b001:         w_taken = !bp.BrEq;
            3'b100, 3'b110: w_taken = bp.BrLT;
            3'b101, 3'b111: w_taken = !bp.BrLT;
            default:        w_legal = 1'b0;
        endcase
    end

    assign w_res   = bp.ex_valid && bp.ex_is_branch && w_legal;
    // A non-branch that was predicted taken is a stale BTB alias and must fall through.
    assign w_alias = bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken;

    assign w_mispredict = (w_res && ((w_taken != bp.ex_pred_taken) ||
                                     (w_taken && (bp.ex_target != bp.ex_pred_target))))
                        || w_alias;

    assign w_exPcPlus4    = bp.ex_pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign bp.mispredict  = w_mispredict;
    assign bp.redirect_pc = (w_res && w_taken) ? bp.ex_target : w_exPcPlus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_res) begin
            if (w_exHit) begin
                if (w_taken) begin
                    if (r_ctr[w_exIdx] != 2'b11) r_ctr[w_exIdx] <= r_ctr[w_exIdx] + 2'd1;
                    r_target[w_exIdx] <= bp.ex_target;
                end else if (r_ctr[w_exIdx] != 2'b00) begin
                    r_ctr[w_exIdx] <= r_ctr[w_exIdx] - 2'd1;
                end
            end else if (w_taken) begin
                r_valid[w_exIdx]  <= 1'b1;
                r_tag[w_exIdx]    <= bp.ex_pc[XLEN-1:IDX_W+2];
                r_target[w_exIdx] <= bp.ex_target;
                r_ctr[w_exIdx]    <= 2'b10;
            end
        end else if (w_alias && w_exHit) begin
            r_valid[w_exIdx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brCnt <= '0;
            r_mpCnt <= '0;
        end else begin
            if (w_res && (r_brCnt != 32'hFFFF_FFFF))        r_brCnt <= r_brCnt + 32'd1;
            if (w_mispredict && (r_mpCnt != 32'hFFFF_FFFF)) r_mpCnt <= r_mpCnt + 32'd1;
        end
    end

    assign bp.br_cnt = r_brCnt;
    assign bp.mp_cnt = r_mpCnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// tb_branch_predictor : directed + randomized checks against a table-level model
// Revision: 1.0
// ============================================================================
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bp ();
    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (.clk(clk), .rst_n(rst_n), .bp(bp));

    // Reference model: per-entry state kept as plain integers.
    bit          mValid  [ENTRIES];
    logic [31:0] mTag    [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCtr    [ENTRIES];
    logic [31:0] mBr;
    logic [31:0] mMp;

    function automatic int idxOf(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction
    function automatic logic [31:0] tagOf(logic [31:0] pc);
        return pc >> (2 + $clog2(ENTRIES));
    endfunction
    function automatic bit hitOf(logic [31:0] pc);
        return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
    endfunction
    function automatic bit predOf(logic [31:0] pc);
        return hitOf(pc) && (mCtr[idxOf(pc)] >= 2);
    endfunction
    function automatic bit legalOf(logic [2:0] f3);
        return (f3 != 3'd2) && (f3 != 3'd3);
    endfunction
    function automatic bit outcomeOf(logic [2:0] f3, logic eq, logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction
    function automatic bit resNow();
        return bp.ex_valid && bp.ex_is_branch && legalOf(bp.ex_funct3);
    endfunction
    function automatic bit takenNow();
        return resNow() && outcomeOf(bp.ex_funct3, bp.BrEq, bp.BrLT);
    endfunction
    function automatic bit expMp();
        if (resNow())
            return (takenNow() != bp.ex_pred_taken) ||
                   (takenNow() && (bp.ex_target != bp.ex_pred_target));
        return bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken;
    endfunction
    function automatic logic [31:0] expRedirect();
        return takenNow() ? bp.ex_target : bp.ex_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0; mTag[i] = '0; mTarget[i] = '0; mCtr[i] = 1;
        end
        mBr = '0;
        mMp = '0;
    endtask

    // Applies the effect of the upcoming clock edge to the model.
    task automatic model_commit();
        int  i;
        bit  tk;
        i  = idxOf(bp.ex_pc);
        tk = takenNow();
        if (expMp() && (mMp != 32'hFFFF_FFFF)) mMp = mMp + 1;
        if (resNow()) begin
            if (mBr != 32'hFFFF_FFFF) mBr = mBr + 1;
            if (hitOf(bp.ex_pc)) begin
                if (tk) begin
                    if (mCtr[i] < 3) mCtr[i] = mCtr[i] + 1;
                    mTarget[i] = bp.ex_target;
                end else if (mCtr[i] > 0) begin
                    mCtr[i] = mCtr[i] - 1;
                end
            end else if (tk) begin
                mValid[i] = 1'b1; mTag[i] = tagOf(bp.ex_pc); mTarget[i] = bp.ex_target; mCtr[i] = 2;
            end
        end else if (bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken && hitOf(bp.ex_pc)) begin
            mValid[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic eq, input logic lt);
        bp.ex_valid = v; bp.ex_is_branch = br; bp.ex_pc = pc; bp.ex_funct3 = f3;
        bp.ex_target = tgt; bp.ex_pred_taken = pt; bp.ex_pred_target = ptgt;
        bp.BrEq = eq; bp.BrLT = lt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 3'd0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bp.if_pc = $urandom & 32'hFFFF_FFFC;
            #1;
            total++;
            if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'd0 || bp.br_cnt !== 32'd0 ||
                bp.mp_cnt !== 32'd0 || bp.mispredict !== 1'b0) begin
                bad++;
                $display("FAIL reset pc=%h actual pt=%b tgt=%h br=%0d mp=%0d mis=%b required all zero",
                         bp.if_pc, bp.pred_taken, bp.pred_target, bp.br_cnt, bp.mp_cnt, bp.mispredict);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_taken();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h100, 3'b000, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
        bp.if_pc = 32'h100;
        #1;
        total++;
        if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h80 || bp.BrUn !== 1'b0 || bp.pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL cold_taken actual mis=%b rd=%h brun=%b pt=%b required 1 00000080 0 0",
                     bp.mispredict, bp.redirect_pc, bp.BrUn, bp.pred_taken);
        end
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80 || bp.br_cnt !== mBr || bp.mp_cnt !== mMp) begin
            bad++;
            $display("FAIL cold_lookup actual pt=%b tgt=%h br=%0d mp=%0d required 1 00000080 %0d %0d",
                     bp.pred_taken, bp.pred_target, bp.br_cnt, bp.mp_cnt, mBr, mMp);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 32'h100, 3'b000, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0);
            #1;
            total++;
            if (bp.mispredict !== 1'b0) begin
                bad++;
                $display("FAIL sat_taken%0d actual mis=%b required 0", k, bp.mispredict);
            end
            model_commit();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 32'h100, 3'b000, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
            #1;
            total++;
            if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h104) begin
                bad++;
                $display("FAIL sat_nt%0d actual mis=%b rd=%h required 1 00000104", k, bp.mispredict, bp.redirect_pc);
            end
            model_commit();
            @(negedge clk);
            idle();
            bp.if_pc = 32'h100;
            #1;
            total++;
            if (bp.pred_taken !== ((k == 0) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL sat_lookup%0d actual pt=%b required %b", k, bp.pred_taken, (k == 0));
            end
        end
    endtask

    task automatic test_unsigned_decode();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h208, 3'b110, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        total++;
        if (bp.BrUn !== 1'b1 || bp.mispredict !== 1'b0) begin
            bad++;
            $display("FAIL bltu actual brun=%b mis=%b required 1 0", bp.BrUn, bp.mispredict);
        end
        model_commit();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h20C, 3'b011, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1);
        bp.if_pc = 32'h208;
        #1;
        total++;
        if (bp.pred_taken !== 1'b0 || bp.mispredict !== 1'b0) begin
            bad++;
            $display("FAIL bltu_noalloc actual pt=%b mis=%b required 0 0", bp.pred_taken, bp.mispredict);
        end
        model_commit();
        @(negedge clk);
        idle();
        bp.if_pc = 32'h20C;
        #1;
        total++;
        if (bp.br_cnt !== mBr || bp.pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL illegal_f3 actual br=%0d pt=%b required %0d 0", bp.br_cnt, bp.pred_taken, mBr);
        end
    endtask

    task automatic test_alias();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h100, 3'b001, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
        model_commit();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
        bp.if_pc = 32'h100;
        #1;
        total++;
        if (bp.pred_taken !== 1'b1 || bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h104) begin
            bad++;
            $display("FAIL alias actual pt=%b mis=%b rd=%h required 1 1 00000104",
                     bp.pred_taken, bp.mispredict, bp.redirect_pc);
        end
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bp.pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL alias_clear actual pt=%b required 0", bp.pred_taken);
        end
    endtask

    task automatic test_tag_conflict();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h100, 3'b000, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
        model_commit();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h140, 3'b100, 32'h400, 1'b0, 32'h0, 1'b0, 1'b1);
        model_commit();
        @(negedge clk);
        idle();
        bp.if_pc = 32'h140;
        #1;
        total++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h400) begin
            bad++;
            $display("FAIL conflict_new actual pt=%b tgt=%h required 1 00000400", bp.pred_taken, bp.pred_target);
        end
        bp.if_pc = 32'h100;
        #1;
        total++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
            bad++;
            $display("FAIL conflict_old actual pt=%b tgt=%h required 0 0", bp.pred_taken, bp.pred_target);
        end
    endtask

    task automatic test_counter_saturation();
        @(negedge clk);
        force dut.r_mpCnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_mpCnt;
        mMp = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 32'h300, 3'b000, 32'h0, 1'b1, 32'h44, 1'b0, 1'b0);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bp.mp_cnt !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL mp_saturate actual=%h required=ffffffff", bp.mp_cnt);
        end
    endtask

    task automatic test_reset_mid_update();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h300, 3'b000, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        model_reset();
        bp.if_pc = 32'h300;
        #1;
        total++;
        if (bp.pred_taken !== 1'b0 || bp.br_cnt !== 32'd0 || bp.mp_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid actual pt=%b br=%0d mp=%0d required 0 0 0", bp.pred_taken, bp.br_cnt, bp.mp_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h180, 32'h2C0, 32'h104, 32'h108, 32'h300, 32'h148};
        logic [31:0] pc, tgt, ptgt;
        logic        pt;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            pc   = pool[$urandom_range(0, 7)];
            tgt  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
            pt   = ($urandom_range(0, 2) == 0) ? 1'($urandom) : predOf(pc);
            ptgt = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : tgt;
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), pc, 3'($urandom), tgt, pt, ptgt,
                  1'($urandom), 1'($urandom));
            bp.if_pc = pool[$urandom_range(0, 7)];
            #1;
            total++;
            if (bp.pred_taken !== predOf(bp.if_pc) ||
                bp.pred_target !== (predOf(bp.if_pc) ? mTarget[idxOf(bp.if_pc)] : 32'h0)) begin
                bad++;
                $display("FAIL rnd_lookup pc=%h actual pt=%b tgt=%h required %b %h", bp.if_pc, bp.pred_taken,
                         bp.pred_target, predOf(bp.if_pc), predOf(bp.if_pc) ? mTarget[idxOf(bp.if_pc)] : 32'h0);
            end
            total++;
            if (bp.mispredict !== expMp() || bp.BrUn !== bp.ex_funct3[1] ||
                (expMp() && bp.redirect_pc !== expRedirect())) begin
                bad++;
                $display("FAIL rnd_resolve pc=%h f3=%0d actual mis=%b rd=%h brun=%b required %b %h %b", bp.ex_pc,
                         bp.ex_funct3, bp.mispredict, bp.redirect_pc, bp.BrUn, expMp(), expRedirect(), bp.ex_funct3[1]);
            end
            total++;
            if (bp.br_cnt !== mBr || bp.mp_cnt !== mMp) begin
                bad++;
                $display("FAIL rnd_counters actual br=%0d mp=%0d required %0d %0d", bp.br_cnt, bp.mp_cnt, mBr, mMp);
            end
            model_commit();
        end
    endtask

    initial begin
        bp.if_pc = '0;
        idle();
        test_reset();
        test_cold_taken();
        test_saturation();
        test_unsigned_decode();
        test_alias();
        test_tag_conflict();
        test_counter_saturation();
        test_reset_mid_update();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
